// File: rtl/bridge_pkg.sv
// Shared types and default address map for the CPU-to-slave system bridge.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package bridge_pkg;

  // Bridge transaction state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } bridge_state_e;

  // Slaves are addressed by word, so the two byte-offset bits are dropped.
  localparam int WORD_ADDR_W = 30;

  // Default four-slot map: data memory at 0, then three 16-byte peripheral windows.
  localparam int             DEF_N_DEV     = 4;
  localparam logic [127:0]   DEF_BASE      = {32'h0000_7F20, 32'h0000_7F10,
                                              32'h0000_7F00, 32'h0000_0000};
  localparam logic [127:0]   DEF_MASK      = {32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                              32'hFFFF_FFF0, 32'hFFFF_C000};
  localparam logic [3:0]     DEF_WORD_ONLY = 4'b1110;
  localparam int             DEF_TIMEOUT   = 15;

  // A write is partial when some, but not all, byte lanes are enabled.
  function automatic logic is_partial(input logic [3:0] byteen);
    return (byteen != 4'b0000) && (byteen != 4'b1111);
  endfunction

endpackage

// File: rtl/bridge_decoder.sv
// Address decoder: maps a byte address onto a one-hot slave slot and flags illegal accesses.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle from the current request fields.
module bridge_decoder
  import bridge_pkg::*;
#(
  parameter int                    N_DEV     = DEF_N_DEV,
  parameter logic [N_DEV*32-1:0]   DEV_BASE  = DEF_BASE[N_DEV*32-1:0],
  parameter logic [N_DEV*32-1:0]   DEV_MASK  = DEF_MASK[N_DEV*32-1:0],
  parameter logic [N_DEV-1:0]      WORD_ONLY = DEF_WORD_ONLY[N_DEV-1:0]
) (
  input  logic [31:0]      addr,
  input  logic [3:0]       byteen,
  output logic [N_DEV-1:0] hit,
  output logic             illegal
);

  logic found;
  logic word_only_hit;

  // Scan slots from index 0 upward so the lowest matching slot takes priority.
  always_comb begin
    hit           = '0;
    found         = 1'b0;
    word_only_hit = 1'b0;
    for (int i = 0; i < N_DEV; i++) begin
      if (!found && ((addr & DEV_MASK[i*32 +: 32]) == DEV_BASE[i*32 +: 32])) begin
        hit[i]        = 1'b1;
        found         = 1'b1;
        word_only_hit = WORD_ONLY[i];
      end
    end
    // Unmapped addresses and sub-word writes into word-only slaves never reach a slave.
    illegal = !found || (word_only_hit && is_partial(byteen));
  end

endmodule

// File: rtl/sys_bridge_n.sv
// System bridge: decodes CPU memory-stage accesses onto N slaves and runs the request/ready handshake.
// Latency: 2 cycles request-to-done with an immediate ready, +1 per wait cycle; decode error 1 cycle; timeout TIMEOUT+1.
// Backpressure: pr_stall holds the CPU while a request is decoded or waiting for slave ready.
module sys_bridge_n
  import bridge_pkg::*;
#(
  parameter int                    N_DEV     = DEF_N_DEV,
  parameter logic [N_DEV*32-1:0]   DEV_BASE  = DEF_BASE[N_DEV*32-1:0],
  parameter logic [N_DEV*32-1:0]   DEV_MASK  = DEF_MASK[N_DEV*32-1:0],
  parameter logic [N_DEV-1:0]      WORD_ONLY = DEF_WORD_ONLY[N_DEV-1:0],
  parameter int                    TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  // CPU side
  input  logic                   pr_req,
  input  logic [31:0]            pr_addr,
  input  logic [31:0]            pr_wd,
  input  logic [3:0]             pr_byteen,
  output logic [31:0]            pr_rd,
  output logic                   pr_stall,
  output logic                   pr_done,
  output logic                   pr_err,
  // Slave side
  output logic [N_DEV-1:0]       dev_sel,
  output logic [WORD_ADDR_W-1:0] dev_addr,
  output logic [31:0]            dev_wd,
  output logic [3:0]             dev_byteen,
  output logic                   dev_we,
  input  logic [N_DEV*32-1:0]    dev_rd,
  input  logic [N_DEV-1:0]       dev_ready,
  input  logic [N_DEV-1:0]       dev_irq,
  // CP0 hardware interrupts
  output logic [5:0]             hw_int
);

  // The counter only has to reach TIMEOUT-1; the FSM leaves BUSY there, so it never wraps.
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bridge_state_e          state;
  logic [N_DEV-1:0]       sel_q;
  logic [CNT_W-1:0]       cnt;
  logic [31:0]            rd_q;
  logic                   err_q;
  logic [WORD_ADDR_W-1:0] addr_q;
  logic [31:0]            wd_q;
  logic [3:0]             byteen_q;
  logic [5:0]             hw_int_q;

  logic [N_DEV-1:0]       dec_hit;
  logic                   dec_illegal;
  logic [31:0]            sel_rd;
  logic                   sel_ready;
  logic [5:0]             irq_ext;

  bridge_decoder #(
    .N_DEV     (N_DEV),
    .DEV_BASE  (DEV_BASE),
    .DEV_MASK  (DEV_MASK),
    .WORD_ONLY (WORD_ONLY)
  ) u_decoder (
    .addr    (pr_addr),
    .byteen  (pr_byteen),
    .hit     (dec_hit),
    .illegal (dec_illegal)
  );

  // Pick read data and ready from the selected slave only; other slaves' ready is ignored.
  always_comb begin
    sel_rd    = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < N_DEV; i++) begin
      if (sel_q[i]) begin
        sel_rd    = sel_rd | dev_rd[i*32 +: 32];
        sel_ready = sel_ready | dev_ready[i];
      end
    end
  end

  // Transaction FSM: latch and decode in IDLE, wait for ready or timeout in BUSY, report in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel_q    <= '0;
      cnt      <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      byteen_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pr_req) begin
            addr_q   <= pr_addr[31:2];
            wd_q     <= pr_wd;
            byteen_q <= pr_byteen;
            cnt      <= '0;
            if (dec_illegal) begin
              // Rejected at decode: no slave is ever selected.
              sel_q <= '0;
              rd_q  <= '0;
              err_q <= 1'b1;
              state <= RESP;
            end else begin
              sel_q <= dec_hit;
              err_q <= 1'b0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (sel_ready) begin
            rd_q  <= sel_rd;
            err_q <= 1'b0;
            sel_q <= '0;
            state <= RESP;
          end else if (cnt == CNT_LAST) begin
            // Slave never answered within the wait budget.
            rd_q  <= '0;
            err_q <= 1'b1;
            sel_q <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          // pr_req is deliberately not looked at here; the next access starts in IDLE.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Zero-extend the slave interrupt lines to the six CP0 inputs.
  always_comb begin
    irq_ext             = '0;
    irq_ext[N_DEV-1:0]  = dev_irq;
  end

  // One-cycle interrupt register toward CP0.
  always_ff @(posedge clk) begin
    if (reset) begin
      hw_int_q <= '0;
    end else begin
      hw_int_q <= irq_ext;
    end
  end

  // CPU-facing outputs are decoded from registered state; only the IDLE stall looks at pr_req.
  always_comb begin
    pr_stall   = ((state == IDLE) && pr_req) || (state == BUSY);
    pr_done    = (state == RESP);
    pr_rd      = (state == RESP) ? rd_q : 32'd0;
    pr_err     = (state == RESP) && err_q;
    dev_sel    = (state == BUSY) ? sel_q : '0;
    dev_we     = (state == BUSY) && (byteen_q != 4'b0000);
    dev_addr   = addr_q;
    dev_wd     = wd_q;
    dev_byteen = byteen_q;
    hw_int     = hw_int_q;
  end

endmodule

// File: tb/tb_sys_bridge_n.sv
// Self-checking bench for sys_bridge_n: transaction-level latency model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_sys_bridge_n;

  localparam int         TIMEOUT_P   = 15;
  localparam logic [3:0] WORD_ONLY_P = 4'b1110;

  logic         clk;
  logic         reset;
  logic         pr_req;
  logic [31:0]  pr_addr;
  logic [31:0]  pr_wd;
  logic [3:0]   pr_byteen;
  logic [31:0]  pr_rd;
  logic         pr_stall;
  logic         pr_done;
  logic         pr_err;
  logic [3:0]   dev_sel;
  logic [29:0]  dev_addr;
  logic [31:0]  dev_wd;
  logic [3:0]   dev_byteen;
  logic         dev_we;
  logic [127:0] dev_rd;
  logic [3:0]   dev_ready;
  logic [3:0]   dev_irq;
  logic [5:0]   hw_int;

  sys_bridge_n #(
    .N_DEV     (4),
    .DEV_BASE  ({32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000}),
    .DEV_MASK  ({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000}),
    .WORD_ONLY (WORD_ONLY_P),
    .TIMEOUT   (TIMEOUT_P)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pr_req     (pr_req),
    .pr_addr    (pr_addr),
    .pr_wd      (pr_wd),
    .pr_byteen  (pr_byteen),
    .pr_rd      (pr_rd),
    .pr_stall   (pr_stall),
    .pr_done    (pr_done),
    .pr_err     (pr_err),
    .dev_sel    (dev_sel),
    .dev_addr   (dev_addr),
    .dev_wd     (dev_wd),
    .dev_byteen (dev_byteen),
    .dev_we     (dev_we),
    .dev_rd     (dev_rd),
    .dev_ready  (dev_ready),
    .dev_irq    (dev_irq),
    .hw_int     (hw_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected outputs for the current cycle, set by the driver.
  logic        chk_main = 1'b0;
  logic        chk_hw   = 1'b0;
  logic        chk_busy, chk_data, chk_latch0;
  logic        exp_stall, exp_done, exp_err, exp_we;
  logic [31:0] exp_rd, exp_wd;
  logic [3:0]  exp_sel, exp_be;
  logic [29:0] exp_addr;
  logic [5:0]  exp_hw;

  // Observations for the directed literal checks.
  int          start_cyc, obs_done_cyc, done_cnt, we_cnt, sel_cnt;
  logic [31:0] obs_rd;
  logic        obs_err;
  logic [3:0]  obs_sel;
  logic [29:0] obs_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Compare process: DUT against the model's per-cycle expectations.
  always @(negedge clk) begin
    if (chk_main) begin
      chk("pr_stall", 32'(pr_stall), 32'(exp_stall));
      chk("pr_done",  32'(pr_done),  32'(exp_done));
      chk("dev_sel",  32'(dev_sel),  32'(exp_sel));
      chk("dev_we",   32'(dev_we),   32'(exp_we));
      if (chk_busy) begin
        chk("dev_addr",   32'(dev_addr),   32'(exp_addr));
        chk("dev_wd",     dev_wd,          exp_wd);
        chk("dev_byteen", 32'(dev_byteen), 32'(exp_be));
      end
      if (chk_data) begin
        chk("pr_err", 32'(pr_err), 32'(exp_err));
        chk("pr_rd",  pr_rd,       exp_rd);
      end
      if (chk_latch0) begin
        chk("dev_addr_rst",   32'(dev_addr),   32'd0);
        chk("dev_wd_rst",     dev_wd,          32'd0);
        chk("dev_byteen_rst", 32'(dev_byteen), 32'd0);
      end
    end
    if (chk_hw) chk("hw_int", 32'(hw_int), 32'(exp_hw));
    if (pr_done === 1'b1) begin
      obs_done_cyc = cyc;
      obs_rd       = pr_rd;
      obs_err      = pr_err;
      done_cnt++;
    end
    if (dev_we === 1'b1) we_cnt++;
    if (dev_sel !== 4'b0000) begin
      sel_cnt++;
      obs_sel  = dev_sel;
      obs_addr = dev_addr;
    end
  end

  // Reference decode: lowest slot whose masked address equals its base, -1 when unmapped.
  function automatic int model_slot(input logic [31:0] a);
    logic [31:0] base [4];
    logic [31:0] mask [4];
    base = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10, 32'h0000_7F20};
    mask = '{32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    for (int i = 0; i < 4; i++) if ((a & mask[i]) == base[i]) return i;
    return -1;
  endfunction

  task automatic set_idle_exp();
    exp_stall  = 1'b0; exp_done = 1'b0; exp_sel = 4'd0; exp_we = 1'b0;
    chk_busy   = 1'b0; chk_data = 1'b0; chk_latch0 = 1'b0;
  endtask

  // Advance one clock; interrupt expectation is the irq level seen during the cycle just ended.
  task automatic next_cycle();
    logic [5:0] h;
    h = reset ? 6'd0 : {2'b00, dev_irq};
    @(posedge clk);
    #1;
    exp_hw    = h;
    dev_irq   = 4'($urandom);
    dev_ready = 4'($urandom);
    for (int i = 0; i < 4; i++) dev_rd[i*32 +: 32] = $urandom;
  endtask

  task automatic idle_cycle();
    next_cycle();
    reset  = 1'b0;
    pr_req = 1'b0;
    set_idle_exp();
    chk_main = 1'b1;
  endtask

  // One CPU access; waits = slave wait cycles before ready (>= TIMEOUT means never ready).
  task automatic do_txn(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                        input int waits, input int abort_in, input bit rnd_abort,
                        input bit frc, input logic [31:0] frc_val);
    int          slot, lat, abort_at;
    bit          legal, terr;
    logic [31:0] cap;
    slot  = model_slot(a);
    legal = (slot >= 0) && !(WORD_ONLY_P[slot] && be != 4'b0000 && be != 4'b1111);
    terr  = legal && (waits >= TIMEOUT_P);
    lat   = !legal ? 1 : (terr ? TIMEOUT_P + 1 : waits + 2);
    abort_at = abort_in;
    if (rnd_abort && legal) abort_at = $urandom_range(1, lat - 1);
    cap = 32'd0; done_cnt = 0; we_cnt = 0; sel_cnt = 0;
    for (int k = 0; k <= lat; k++) begin
      next_cycle();
      set_idle_exp();
      chk_main = 1'b1;
      if (k == 0) begin
        pr_req = 1'b1; pr_addr = a; pr_wd = wd; pr_byteen = be;
        start_cyc = cyc;
        exp_stall = 1'b1;
      end else if (k == abort_at) begin
        reset    = 1'b1;
        chk_main = 1'b0;
      end else if (k < lat) begin
        exp_stall = 1'b1;
        exp_sel   = 4'(1 << slot);
        exp_we    = (be != 4'b0000);
        exp_addr  = a[31:2];
        exp_wd    = wd;
        exp_be    = be;
        chk_busy  = 1'b1;
        dev_ready[slot] = (k - 1 == waits);
        if (frc) dev_rd[slot*32 +: 32] = frc_val;
        if (k - 1 == waits) cap = dev_rd[slot*32 +: 32];
      end else begin
        pr_req   = 1'($urandom_range(0, 1));
        pr_addr  = $urandom;
        exp_done = 1'b1;
        chk_data = 1'b1;
        exp_err  = !legal || terr;
        exp_rd   = exp_err ? 32'd0 : cap;
      end
      if (k == abort_at) begin
        next_cycle();
        reset  = 1'b0;
        pr_req = 1'b0;
        set_idle_exp();
        chk_main = 1'b1; chk_data = 1'b1; chk_latch0 = 1'b1;
        exp_err  = 1'b0; exp_rd = 32'd0;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    int          w, r;
    reset = 1'b1; pr_req = 1'b0; pr_addr = '0; pr_wd = '0; pr_byteen = '0;
    dev_rd = '0; dev_ready = '0; dev_irq = '0;
    repeat (2) @(posedge clk);
    next_cycle();
    reset = 1'b0;
    set_idle_exp();
    chk_main = 1'b1; chk_hw = 1'b1; chk_data = 1'b1; chk_latch0 = 1'b1;
    exp_err = 1'b0; exp_rd = 32'd0;

    // Read from data memory, ready on the first BUSY cycle.
    do_txn(32'h0000_0010, 4'b0000, 32'd0, 0, -1, 0, 1, 32'hDEAD_BEEF);
    idle_cycle();
    chk("t1_latency", 32'(obs_done_cyc - start_cyc), 32'd2);
    chk("t1_rd",      obs_rd,        32'hDEAD_BEEF);
    chk("t1_err",     32'(obs_err),  32'd0);

    // Full-word write to slot 1 after three wait cycles.
    do_txn(32'h0000_7F04, 4'b1111, 32'h5, 3, -1, 0, 0, 32'd0);
    idle_cycle();
    chk("t2_latency", 32'(obs_done_cyc - start_cyc), 32'd5);
    chk("t2_sel",     32'(obs_sel),  32'h2);
    chk("t2_addr",    32'(obs_addr), 32'h1FC1);
    chk("t2_we_cyc",  32'(we_cnt),   32'd4);

    // Partial write into a word-only slot is rejected at decode.
    do_txn(32'h0000_7F14, 4'b0011, 32'h1234, 0, -1, 0, 0, 32'd0);
    idle_cycle();
    chk("t3_latency", 32'(obs_done_cyc - start_cyc), 32'd1);
    chk("t3_err",     32'(obs_err),  32'd1);
    chk("t3_sel_cyc", 32'(sel_cnt),  32'd0);

    // Unmapped read.
    do_txn(32'h0000_9000, 4'b0000, 32'd0, 0, -1, 0, 0, 32'd0);
    idle_cycle();
    chk("t4_err", 32'(obs_err), 32'd1);
    chk("t4_rd",  obs_rd,       32'd0);

    // Slot 3 never answers: timeout.
    do_txn(32'h0000_7F20, 4'b0000, 32'd0, 99, -1, 0, 0, 32'd0);
    idle_cycle();
    chk("t5_latency", 32'(obs_done_cyc - start_cyc), 32'd16);
    chk("t5_err",     32'(obs_err), 32'd1);

    // Reset in the second BUSY cycle aborts silently; the next read works.
    do_txn(32'h0000_7F00, 4'b0000, 32'd0, 10, 2, 0, 0, 32'd0);
    idle_cycle();
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    do_txn(32'h0000_0020, 4'b0000, 32'd0, 1, -1, 0, 0, 32'd0);
    idle_cycle();
    chk("t6_latency", 32'(obs_done_cyc - start_cyc), 32'd3);
    chk("t6_err",     32'(obs_err), 32'd0);

    // Interrupt register: one-cycle delay, zero-extended, cleared by reset.
    idle_cycle();
    dev_irq = 4'b0101;
    idle_cycle();
    @(negedge clk);
    chk("irq_lit", 32'(hw_int), 32'h05);
    next_cycle();
    reset = 1'b1; chk_main = 1'b0;
    idle_cycle();
    @(negedge clk);
    chk("irq_reset", 32'(hw_int), 32'h00);

    // Randomised traffic against the model.
    repeat (300) begin
      r = $urandom_range(0, 5);
      case (r)
        0: a = $urandom & 32'h0000_3FFF;
        1: a = 32'h0000_7F00 | 32'($urandom_range(0, 15));
        2: a = 32'h0000_7F10 | 32'($urandom_range(0, 15));
        3: a = 32'h0000_7F20 | 32'($urandom_range(0, 15));
        4: a = 32'h0000_9000 + 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      r = $urandom_range(0, 2);
      be = (r == 0) ? 4'b0000 : ((r == 1) ? 4'b1111 : 4'($urandom));
      r = $urandom_range(0, 9);
      if (r < 6)       w = r;
      else if (r == 6) w = TIMEOUT_P - 1;
      else if (r == 7) w = TIMEOUT_P;
      else if (r == 8) w = $urandom_range(16, 20);
      else             w = 0;
      do_txn(a, be, $urandom, w, -1, ($urandom_range(0, 19) == 0), 0, 32'd0);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
